// File: rtl/psum_col_fifo.sv
// psum_col_fifo: per-lane partial-sum FIFO at the bottom edge of a PE array.
// Each of the col lanes is an independent circular buffer. Lanes fill at
// their own pace (skewed arrival), and a row is popped from all lanes at once.
// Optional feature macro: PSUM_COL_FIFO_ERR_EN enables the sticky err flag.
//
// Handshake: o_valid means every lane holds at least one entry and out shows
// a complete row. A pop happens on a posedge only when rd=1 and o_valid=1.
// o_ready means no lane is full. A write strobe wr[c] is accepted only if
// lane c was not full before the edge; otherwise that write is dropped.
module psum_col_fifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [psum_bw*col-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [psum_bw*col-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     err
);

    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] depth_cnt = cw'(depth);

    logic [psum_bw-1:0] mem [col][depth];
    logic [aw-1:0]      wptr [col];
    logic [aw-1:0]      rptr [col];
    logic [cw-1:0]      cnt  [col];

    logic [col-1:0] lane_full;
    logic [col-1:0] lane_nonempty;
    logic [col-1:0] push;
    logic           pop;

    // Per-lane status and write acceptance, all from pre-edge counts.
    always_comb begin
        lane_full     = '0;
        lane_nonempty = '0;
        push          = '0;
        for (int c = 0; c < col; c++) begin
            lane_full[c]     = (cnt[c] == depth_cnt);
            lane_nonempty[c] = (cnt[c] != '0);
            push[c]          = wr[c] && !lane_full[c];
        end
    end

    assign o_valid = &lane_nonempty;
    assign pop     = rd && o_valid;
    assign o_full  = |lane_full;
    assign o_ready = !o_full;

    // Storage write; contents need no reset because out is masked by o_valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (push[c]) begin
                mem[c][wptr[c]] <= in[psum_bw*c +: psum_bw];
            end
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (depth is 2^aw).
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (reset) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
            end else begin
                if (push[c]) begin
                    wptr[c] <= wptr[c] + 1'b1;
                end
                if (pop) begin
                    rptr[c] <= rptr[c] + 1'b1;
                end
                case ({push[c], pop})
                    2'b10:   cnt[c] <= cnt[c] + 1'b1;
                    2'b01:   cnt[c] <= cnt[c] - 1'b1;
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    // First-word-fall-through head of every lane, zeroed unless a full row exists.
    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int c = 0; c < col; c++) begin
                out[psum_bw*c +: psum_bw] = mem[c][rptr[c]];
            end
        end
    end

`ifdef PSUM_COL_FIFO_ERR_EN
    logic err_q;

    // Sticky flag: any dropped write or any rd without a complete row.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((|(wr & lane_full)) || (rd && !o_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/psum_col_fifo.md
PSUM_COL_FIFO -- requirements
Module: psum_col_fifo

Interface
REQ-001 Parameter: col, 8, number of PE columns (lanes).
REQ-002 Parameter: psum_bw, 16, partial-sum width per lane.
REQ-003 Parameter: depth, 64, entries per lane (power of 2, >=2).
REQ-004 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: in  input  psum_bw*col  per-lane psums from array bottom edge; lane c at bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 Port: wr  input  col  per-lane write strobe (array per-lane valid).
REQ-008 Port: rd  input  1  pop one full row (all lanes).
REQ-009 Port: out  output  psum_bw*col  head entry of every lane, same lane packing as in.
REQ-010 Port: o_valid  output  1  all lanes non-empty; out holds a complete row.
REQ-011 Port: o_full  output  1  at least one lane full.
REQ-012 Port: o_ready  output  1  no lane full (inverse of o_full).
REQ-013 Port: err  output  1  sticky error flag (see Configuration).

Function
REQ-014 Each lane SHALL be an independent circular FIFO of depth entries with its own write pointer, read pointer and occupancy count (0..depth).
REQ-015 Write: on a posedge with wr[c]=1 and lane c not full (count before the edge), in lane c SHALL be stored at wptr_c; wptr_c increments modulo depth.
REQ-016 A write to a full lane SHALL be dropped, even if rd pops that lane in the same cycle; storage and pointers unchanged.
REQ-017 o_valid SHALL be combinational: 1 iff every lane count >= 1.
REQ-018 Read: rd=1 while o_valid=1 SHALL advance every lane's rptr by one, modulo depth, at the posedge.
REQ-019 rd=1 while o_valid=0 SHALL be ignored (no lane pops, including non-empty lanes).
REQ-020 out SHALL be first-word-fall-through: lane c shows the entry at rptr_c combinationally; out SHALL be all-zero whenever o_valid=0.
REQ-021 Simultaneous accepted write and read on a lane SHALL leave its count unchanged; order preserved.
REQ-022 Write to an empty lane SHALL be visible on out (if all other lanes non-empty) the cycle after the write edge; zero-cycle bypass SHALL NOT occur.
REQ-023 Lanes SHALL accept writes skewed in time (lane c up to col-1 cycles after lane 0); rows re-align by pointer order, not by arrival cycle.
REQ-024 o_full and o_ready SHALL be combinational from post-edge counts; pointer wrap SHALL NOT disturb ordering or flags.

Reset
REQ-025 reset=1 at a posedge SHALL zero all pointers and counts in every lane, regardless of wr/rd on that edge.
REQ-026 After reset: o_valid=0, out=0, o_full=0, o_ready=1, err=0; storage contents are don't-care (masked by REQ-020).
REQ-027 Reset asserted mid-operation SHALL discard all stored rows; the first post-reset write behaves as into an empty FIFO.

Configuration
REQ-028 Macro PSUM_COL_FIFO_ERR_EN SHALL control error detection.
REQ-029 With PSUM_COL_FIFO_ERR_EN defined: err SHALL set on the edge after any dropped write (REQ-016) or ignored rd (REQ-019), and hold until reset.
REQ-030 Without PSUM_COL_FIFO_ERR_EN: err SHALL be constant 0, no error logic synthesized; all other behaviour identical.

Verification
REQ-031 Reset, then write 0x0001..0x0008 to lanes 0..7 all in one cycle (wr=0xFF) -> next cycle o_valid=1, out lane c = c+1; rd=1 -> next cycle o_valid=0, out=0.
REQ-032 Skewed writes: lane c written value 0x0100+c at cycle c (wr one-hot, shifting) -> o_valid stays 0 until cycle after lane 7 write, then one row 0x0100..0x0107.
REQ-033 Fill lane 3 with 64 writes (others empty) -> o_full=1, o_ready=0; 65th write value 0xDEAD dropped; err=1 with macro, 0 without; after filling other lanes, 64 pops return lane 3 values in order, no 0xDEAD.
REQ-034 Stream 200 rows with wr=0xFF and rd=1 every cycle after first row -> counts stay at 1, outputs in order across 3 pointer wraps, o_full never 1.
REQ-035 rd=1 with lanes 0..6 holding one entry, lane 7 empty -> no pop; lane 7 written next -> row of first entries appears intact; err=1 with macro.
REQ-036 Reset asserted with 10 rows stored and rd=1, wr=0xFF on same edge -> o_valid=0, o_ready=1, err=0 next cycle; a fresh row written afterwards reads back unchanged.
